l2_spi_shifter: RTL and testbench

L2_SPI_SHIFTER -- requirements
Module: l2_spi_shifter

---
 rtl/l2_spi_shifter.sv | 137 +++++++++++++
 tb/tb_l2_spi_shifter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_spi_shifter.sv
// SPI master shift engine; SCLK edges arrive as strobes from a separate clock-counter stage.
// Define L2_SPI_SHIFTER_LSB_FIRST_EN for LSB-first framing (MSB-first otherwise).
module l2_spi_shifter #(
  parameter logic CPOL       = 1'b0,
  parameter logic CPHA       = 1'b0,
  parameter int   DATA_WIDTH = 8,
  parameter int   CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_up_edge,
  input  logic                  i_down_edge,
  input  logic                  i_work_end,
  input  logic                  i_miso,
  output logic                  o_work_en,
  output logic                  o_cs_n,
  output logic                  o_mosi,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] SAMPLE_LIMIT = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] SHIFT_LIMIT  = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] tx_reg, rx_reg, rx_out_reg;
  logic [DATA_WIDTH-1:0] tx_shifted, rx_shifted;
  logic [CNT_WIDTH-1:0]  sample_cnt_reg, shift_cnt_reg;
  logic                  lead_seen_reg;
  logic                  lead_edge, trail_edge, sample_en, shift_en;

`ifdef L2_SPI_SHIFTER_LSB_FIRST_EN
  assign tx_shifted = {1'b0, tx_reg[DATA_WIDTH-1:1]};
  assign rx_shifted = {i_miso, rx_reg[DATA_WIDTH-1:1]};
  assign o_mosi     = tx_reg[0];
`else
  assign tx_shifted = {tx_reg[DATA_WIDTH-2:0], 1'b0};
  assign rx_shifted = {rx_reg[DATA_WIDTH-2:0], i_miso};
  assign o_mosi     = tx_reg[DATA_WIDTH-1];
`endif

  assign o_rx_data = rx_out_reg;

  // Simultaneous strobes are treated as a glitch and dropped entirely.
  always_comb begin
    lead_edge  = 1'b0;
    trail_edge = 1'b0;
    sample_en  = 1'b0;
    shift_en   = 1'b0;
    if (state_reg == SHIFT && !(i_up_edge && i_down_edge)) begin
      lead_edge  = CPOL ? i_down_edge : i_up_edge;
      trail_edge = CPOL ? i_up_edge : i_down_edge;
    end
    if (CPHA) begin
      sample_en = trail_edge;
      shift_en  = lead_edge && lead_seen_reg;
    end else begin
      sample_en = lead_edge;
      shift_en  = trail_edge;
    end
    sample_en = sample_en && (sample_cnt_reg < SAMPLE_LIMIT);
    shift_en  = shift_en && (shift_cnt_reg < SHIFT_LIMIT);
  end

  always_comb begin
    state_next = state_reg;
    o_work_en  = 1'b0;
    o_cs_n     = 1'b1;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_next = SETUP;
      end
      SETUP: begin
        o_cs_n     = 1'b0;
        state_next = SHIFT;
      end
      SHIFT: begin
        o_cs_n    = 1'b0;
        o_work_en = 1'b1;
        if (i_work_end) state_next = HOLD;
      end
      HOLD: begin
        o_cs_n     = 1'b0;
        state_next = DONE;
      end
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        o_busy     = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      tx_reg         <= '0;
      rx_reg         <= '0;
      rx_out_reg     <= '0;
      sample_cnt_reg <= '0;
      shift_cnt_reg  <= '0;
      lead_seen_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && i_start) begin
        tx_reg         <= i_tx_data;
        rx_reg         <= '0;
        sample_cnt_reg <= '0;
        shift_cnt_reg  <= '0;
        lead_seen_reg  <= 1'b0;
      end
      // First leading edge only arms shifting in CPHA=1 mode; bit 0 is already on MOSI.
      if (lead_edge) lead_seen_reg <= 1'b1;
      if (shift_en) begin
        tx_reg        <= tx_shifted;
        shift_cnt_reg <= shift_cnt_reg + 1'b1;
      end
      if (sample_en) begin
        rx_reg         <= rx_shifted;
        sample_cnt_reg <= sample_cnt_reg + 1'b1;
      end
      if (state_reg == HOLD) rx_out_reg <= rx_reg;
    end
  end

endmodule

// File: tb/tb_l2_spi_shifter.sv
// Bench for l2_spi_shifter: one CPOL0/CPHA0 and one CPOL1/CPHA1 instance driven by modelled SCLK strobes.
module tb_l2_spi_shifter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start = '0, up = '0, down = '0, work_end = '0, miso = '0;
  logic [1:0][W-1:0] tx_data = '0;
  logic [1:0] work_en, cs_n, mosi, busy, done;
  logic [1:0][W-1:0] rx_data;

  int errors = 0;
  int checks = 0;
  int done_cnt [2] = '{0, 0};
  int up_cs_cnt [2] = '{0, 0};
  bit lsb_first;

  always #5 clk = ~clk;

  l2_spi_shifter #(.CPOL(1'b0), .CPHA(1'b0), .DATA_WIDTH(W), .CNT_WIDTH(4)) dut0 (
    .clk(clk), .rst(rst), .i_start(start[0]), .i_tx_data(tx_data[0]),
    .i_up_edge(up[0]), .i_down_edge(down[0]), .i_work_end(work_end[0]), .i_miso(miso[0]),
    .o_work_en(work_en[0]), .o_cs_n(cs_n[0]), .o_mosi(mosi[0]), .o_rx_data(rx_data[0]),
    .o_busy(busy[0]), .o_done(done[0])
  );

  l2_spi_shifter #(.CPOL(1'b1), .CPHA(1'b1), .DATA_WIDTH(W), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .i_start(start[1]), .i_tx_data(tx_data[1]),
    .i_up_edge(up[1]), .i_down_edge(down[1]), .i_work_end(work_end[1]), .i_miso(miso[1]),
    .o_work_en(work_en[1]), .o_cs_n(cs_n[1]), .o_mosi(mosi[1]), .o_rx_data(rx_data[1]),
    .o_busy(busy[1]), .o_done(done[1])
  );

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done[d]) done_cnt[d]++;
      if (up[d] && !cs_n[d]) up_cs_cnt[d]++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic logic bit_at(input logic [W-1:0] word, input int k);
    return lsb_first ? word[k] : word[W-1-k];
  endfunction

  // dut1 is the CPOL=1/CPHA=1 instance
  function automatic bit cpol_of(input int d);
    return d == 1;
  endfunction

  function automatic bit cpha_of(input int d);
    return d == 1;
  endfunction

  task automatic check_idle(input int d);
    check("idle_cs_n", d, 32'(cs_n[d]), 32'd1);
    check("idle_work_en", d, 32'(work_en[d]), 32'd0);
    check("idle_busy", d, 32'(busy[d]), 32'd0);
    check("idle_done", d, 32'(done[d]), 32'd0);
  endtask

  task automatic run_frame(input int d, input logic [W-1:0] tx, input logic [W-1:0] sw,
                           input bit loop, input bit restart, input bit spurious, input bit both);
    logic [W-1:0] slave_rx, exp_rx;
    logic m;
    int done0, up0, nboth;
    slave_rx = '0;
    nboth    = 0;
    done0    = done_cnt[d];
    up0      = up_cs_cnt[d];
    exp_rx   = loop ? tx : sw;
    @(negedge clk);
    start[d]   = 1'b1;
    tx_data[d] = tx;
    @(negedge clk);
    start[d]   = restart;
    tx_data[d] = ~tx;
    check("setup_cs_n", d, 32'(cs_n[d]), 32'd0);
    check("setup_busy", d, 32'(busy[d]), 32'd1);
    check("setup_work_en", d, 32'(work_en[d]), 32'd0);
    check("first_mosi", d, 32'(mosi[d]), 32'(bit_at(tx, 0)));
    @(negedge clk);
    check("shift_work_en", d, 32'(work_en[d]), 32'd1);
    for (int k = 0; k < W; k++) begin
      for (int e = 0; e < 2; e++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (both && $urandom_range(0, 3) == 0) begin
          up[d] = 1'b1; down[d] = 1'b1; nboth++;
          @(negedge clk);
          up[d] = 1'b0; down[d] = 1'b0;
        end
        if (e == int'(cpha_of(d))) begin
          m = loop ? mosi[d] : bit_at(sw, k);
          miso[d] = m;
          slave_rx[lsb_first ? k : W-1-k] = mosi[d];
        end
        if ((e == 0) ^ cpol_of(d)) up[d] = 1'b1;
        else down[d] = 1'b1;
        @(negedge clk);
        up[d] = 1'b0; down[d] = 1'b0;
        check("shift_busy", d, 32'(busy[d]), 32'd1);
      end
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check("pre_end_work_en", d, 32'(work_en[d]), 32'd1);
    work_end[d] = 1'b1;
    @(negedge clk);
    work_end[d] = 1'b0;
    check("hold_cs_n", d, 32'(cs_n[d]), 32'd0);
    check("hold_work_en", d, 32'(work_en[d]), 32'd0);
    check("hold_done", d, 32'(done[d]), 32'd0);
    if (spurious) begin
      m = mosi[d];
      up[d] = 1'b1;
      @(negedge clk);
      up[d] = 1'b0;
      check("hold_spur_mosi", d, 32'(mosi[d]), 32'(m));
    end else begin
      @(negedge clk);
    end
    check("done_pulse", d, 32'(done[d]), 32'd1);
    check("done_cs_n", d, 32'(cs_n[d]), 32'd1);
    check("done_rx", d, 32'(rx_data[d]), 32'(exp_rx));
    start[d]   = 1'b1;
    tx_data[d] = 8'($urandom);
    @(negedge clk);
    start[d] = 1'b0;
    check_idle(d);
    check("rx_held", d, 32'(rx_data[d]), 32'(exp_rx));
    check("done_count", d, 32'(done_cnt[d] - done0), 32'd1);
    check("slave_rx", d, 32'(slave_rx), 32'(tx));
    check("sclk_up_count", d, 32'(up_cs_cnt[d] - up0), 32'(W + nboth + int'(spurious)));
    $display("frame dut%0d tx=%02h slave=%02h loop=%0d rx=%02h slave_got=%02h",
             d, tx, sw, loop, rx_data[d], slave_rx);
  endtask

  initial begin
    logic m;
    int done0;
`ifdef L2_SPI_SHIFTER_LSB_FIRST_EN
    lsb_first = 1'b1;
`else
    lsb_first = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_idle(d);
      check("reset_mosi", d, 32'(mosi[d]), 32'd0);
      check("reset_rx", d, 32'(rx_data[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_idle(0);

    run_frame(0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // spurious strobes in IDLE must leave MOSI alone
    m = mosi[0];
    up[0] = 1'b1;
    @(negedge clk);
    up[0] = 1'b0; down[0] = 1'b1;
    @(negedge clk);
    down[0] = 1'b0;
    check("idle_spur_mosi", 0, 32'(mosi[0]), 32'(m));
    check_idle(0);

    run_frame(1, 8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(0, 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      run_frame(i % 2, 8'($urandom), 8'($urandom), i == 2, 1'b1, i[0], 1'b1);

    // reset after the 4th SCLK edge aborts the frame
    done0 = done_cnt[0];
    @(negedge clk);
    start[0] = 1'b1; tx_data[0] = 8'($urandom);
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    for (int e = 0; e < 4; e++) begin
      if (e % 2 == 0) up[0] = 1'b1;
      else down[0] = 1'b1;
      @(negedge clk);
      up[0] = 1'b0; down[0] = 1'b0;
    end
    check("mid_busy", 0, 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_cs_n", 0, 32'(cs_n[0]), 32'd1);
    check("abort_work_en", 0, 32'(work_en[0]), 32'd0);
    check("abort_busy", 0, 32'(busy[0]), 32'd0);
    check("abort_mosi", 0, 32'(mosi[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_done", 0, 32'(done_cnt[0] - done0), 32'd0);
    check_idle(0);
    $display("abort dut0 reset after 4 edges");

    run_frame(0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
